// File: rtl/aa_fir_16.sv
// 16-tap symmetric low-pass FIR with one shared multiplier and a 4:1 decimation strobe.
// Optional build macro FIR_SAT_EN: saturate the rounded output instead of wrapping it.
module aa_fir_16 #(
  parameter int DEC_PHASE = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        samp_en,
  input  logic [17:0] x_in,
  output logic [17:0] y,
  output logic        y_valid,
  output logic        dec_clk_en,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] PHASE = 2'(DEC_PHASE % 4);

  state_t             state_r, state_s;
  logic        [2:0]  k_r;
  logic signed [17:0] d_r [16];
  logic signed [39:0] acc_r;
  logic        [1:0]  cnt_r;

  logic        [3:0]  lo_idx_s, hi_idx_s;
  logic signed [18:0] pre_s;
  logic signed [36:0] prod_s;
  logic signed [39:0] acc_next_s;
  logic        [17:0] y_s;

  // Half of the symmetric coefficient set, 1s17
  function automatic logic signed [17:0] coef(input logic [2:0] k);
    case (k)
      3'd0:    coef = -18'sd4096;
      3'd1:    coef = -18'sd6144;
      3'd2:    coef = 18'sd0;
      3'd3:    coef = 18'sd3072;
      3'd4:    coef = 18'sd7168;
      3'd5:    coef = 18'sd12288;
      3'd6:    coef = 18'sd16384;
      3'd7:    coef = 18'sd18432;
      default: coef = 18'sd0;
    endcase
  endfunction

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (samp_en) state_s = MAC;
        else         state_s = IDLE;
      end
      MAC: begin
        if (k_r == 3'd7) state_s = DONE;
        else             state_s = MAC;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Pre-add of the mirrored taps followed by the single shared multiply
  always_comb begin
    lo_idx_s   = {1'b0, k_r};
    hi_idx_s   = 4'd15 - lo_idx_s;
    pre_s      = {d_r[lo_idx_s][17], d_r[lo_idx_s]} + {d_r[hi_idx_s][17], d_r[hi_idx_s]};
    prod_s     = pre_s * coef(k_r);
    acc_next_s = acc_r + {{3{prod_s[36]}}, prod_s};
  end

`ifdef FIR_SAT_EN
  logic signed [22:0] rnd_s;

  // Round half up, then clamp to the 18-bit signed range
  always_comb begin
    rnd_s = acc_r[39:17] + {22'd0, acc_r[16]};
    if (rnd_s > 23'sd131071) begin
      y_s = 18'h1ffff;
    end else if (rnd_s < -23'sd131072) begin
      y_s = 18'h20000;
    end else begin
      y_s = rnd_s[17:0];
    end
  end
`else
  // Round half up; upper bits are discarded (two's-complement wrap)
  always_comb begin
    y_s = acc_r[34:17] + {17'd0, acc_r[16]};
  end
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Delay line, accumulator, output register and decimation counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 16; j++) d_r[j] <= 18'sd0;
      k_r        <= 3'd0;
      acc_r      <= 40'sd0;
      y          <= 18'd0;
      y_valid    <= 1'b0;
      dec_clk_en <= 1'b0;
      overrun    <= 1'b0;
      cnt_r      <= 2'd0;
    end else begin
      y_valid    <= 1'b0;
      dec_clk_en <= 1'b0;
      case (state_r)
        IDLE: begin
          if (samp_en) begin
            d_r[0] <= x_in;
            for (int j = 1; j < 16; j++) d_r[j] <= d_r[j-1];
            acc_r <= 40'sd0;
            k_r   <= 3'd0;
          end
        end
        MAC: begin
          acc_r <= acc_next_s;
          k_r   <= k_r + 3'd1;
          if (samp_en) overrun <= 1'b1;
        end
        DONE: begin
          y          <= y_s;
          y_valid    <= 1'b1;
          dec_clk_en <= (cnt_r == PHASE);
          cnt_r      <= cnt_r + 2'd1;
          if (samp_en) overrun <= 1'b1;
        end
        default: begin
          k_r <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aa_fir_16.sv
// Self-checking bench for aa_fir_16: two instances (DEC_PHASE 0 and 3) against an event-schedule model.
module tb_aa_fir_16;

  logic        clk = 1'b0;
  logic        reset, samp_en;
  logic [17:0] x_in;
  logic [17:0] y0, y3;
  logic        yv0, yv3, dec0, dec3, ovr0, ovr3;

  always #5 clk = ~clk;

  aa_fir_16 #(.DEC_PHASE(0)) dut0 (
    .clk(clk), .reset(reset), .samp_en(samp_en), .x_in(x_in),
    .y(y0), .y_valid(yv0), .dec_clk_en(dec0), .overrun(ovr0)
  );

  aa_fir_16 #(.DEC_PHASE(3)) dut3 (
    .clk(clk), .reset(reset), .samp_en(samp_en), .x_in(x_in),
    .y(y3), .y_valid(yv3), .dec_clk_en(dec3), .overrun(ovr3)
  );

  int tests = 0;
  int fails = 0;

  // Full 16-entry coefficient set c[j]
  int coef_c [16] = '{-4096, -6144, 0, 3072, 7168, 12288, 16384, 18432,
                      18432, 16384, 12288, 7168, 3072, 0, -6144, -4096};

  // Model state: accepted sample history and a schedule of the next output
  int     hist [16];
  longint edge_n = 0;
  longint avail = 0;
  bit     pend = 1'b0;
  longint pend_edge = 0;
  int     pend_val = 0;
  int     exp_y = 0;
  bit     exp_valid = 1'b0, exp_dec0 = 1'b0, exp_dec3 = 1'b0, exp_ovr = 1'b0;
  int     out_cnt = 0;
  bit     armed = 1'b0;

  int obs_y [$];
  bit obs_d0 [$];
  bit obs_d3 [$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int model_y();
    longint s = 0;
    longint r;
    logic [17:0] w;
    for (int j = 0; j < 16; j++) s += longint'(hist[j]) * longint'(coef_c[j]);
    r = (s + 64'sd65536) >>> 17;
`ifdef FIR_SAT_EN
    if (r > 64'sd131071) r = 64'sd131071;
    else if (r < -64'sd131072) r = -64'sd131072;
    else r = r;
`endif
    w = r[17:0];
    return int'($signed(w));
  endfunction

  function automatic int obs_at(input int i);
    if (i < obs_y.size()) return obs_y[i];
    else return 32'sh7fffffff;
  endfunction

  // Compare outputs of the last edge, then advance the model with the inputs for the next edge
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("y_dp0", int'($signed(y0)), exp_y);
        chk("y_dp3", int'($signed(y3)), exp_y);
        chk("y_valid_dp0", int'(yv0), int'(exp_valid));
        chk("y_valid_dp3", int'(yv3), int'(exp_valid));
        chk("dec_clk_en_dp0", int'(dec0), int'(exp_dec0));
        chk("dec_clk_en_dp3", int'(dec3), int'(exp_dec3));
        chk("overrun_dp0", int'(ovr0), int'(exp_ovr));
        chk("overrun_dp3", int'(ovr3), int'(exp_ovr));
        if (yv0) begin
          obs_y.push_back(int'($signed(y0)));
          obs_d0.push_back(dec0);
          obs_d3.push_back(dec3);
        end
      end
      edge_n++;
      if (!reset) begin
        for (int j = 0; j < 16; j++) hist[j] = 0;
        pend = 1'b0;
        exp_y = 0;
        exp_valid = 1'b0;
        exp_dec0 = 1'b0;
        exp_dec3 = 1'b0;
        exp_ovr = 1'b0;
        out_cnt = 0;
        avail = edge_n + 1;
        armed = 1'b1;
      end else begin
        exp_valid = 1'b0;
        exp_dec0 = 1'b0;
        exp_dec3 = 1'b0;
        if (pend && pend_edge == edge_n) begin
          exp_y = pend_val;
          exp_valid = 1'b1;
          exp_dec0 = (out_cnt == 0);
          exp_dec3 = (out_cnt == 3);
          out_cnt = (out_cnt + 1) % 4;
          pend = 1'b0;
        end
        if (samp_en) begin
          if (edge_n >= avail) begin
            for (int j = 15; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = int'($signed(x_in));
            pend_val = model_y();
            pend_edge = edge_n + 9;
            pend = 1'b1;
            avail = edge_n + 10;
          end else begin
            exp_ovr = 1'b1;
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      x_in = 18'($urandom);
    end
  endtask

  task automatic strobe(input logic [17:0] x, input int gap);
    samp_en = 1'b1;
    x_in = x;
    @(posedge clk);
    #1;
    samp_en = 1'b0;
    x_in = 18'($urandom);
    idle(gap - 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    obs_y.delete();
    obs_d0.delete();
    obs_d3.delete();
  endtask

  int imp_exp [17] = '{-4096, -6144, 0, 3072, 7168, 12288, 16384, 18432,
                       18432, 16384, 12288, 7168, 3072, 0, -6144, -4096, 0};

  initial begin
    reset = 1'b0;
    samp_en = 1'b0;
    x_in = 18'd0;
    idle(3);
    reset = 1'b1;

    // Impulse response and decimation phase
    strobe(18'h1ffff, 10);
    for (int i = 0; i < 16; i++) strobe(18'd0, 10);
    idle(12);
    chk("impulse_count", obs_y.size(), 17);
    for (int i = 0; i < 17; i++) chk($sformatf("impulse_y[%0d]", i), obs_at(i), imp_exp[i]);
    for (int i = 0; i < 8; i++) begin
      if (i < obs_d0.size()) begin
        chk($sformatf("dec_dp0_out%0d", i + 1), int'(obs_d0[i]), (i % 4 == 0) ? 1 : 0);
        chk($sformatf("dec_dp3_out%0d", i + 1), int'(obs_d3[i]), (i % 4 == 3) ? 1 : 0);
      end else begin
        chk("dec_count", obs_d0.size(), 8);
      end
    end

    // DC gain
    do_reset();
    for (int i = 0; i < 18; i++) strobe(18'h1ffff, 10);
    idle(12);
    chk("dc_count", obs_y.size(), 18);
    for (int i = 15; i < 18; i++) chk($sformatf("dc_y[%0d]", i), obs_at(i), 94207);

    // Worst-case magnitude
    do_reset();
    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 1 || i == 14 || i == 15) strobe(18'h20000, 10);
      else strobe(18'h1ffff, 10);
    end
    idle(12);
`ifdef FIR_SAT_EN
    chk("worst_case_y", obs_at(15), 131071);
`else
    chk("worst_case_y", obs_at(15), -126977);
`endif

    // Overrun: second strobe 5 cycles after the first is dropped
    do_reset();
    strobe(18'd50000, 5);
    strobe(18'h2abcd, 10);
    idle(2);
    chk("overrun_set", int'(ovr0), 1);
    chk("overrun_count", obs_y.size(), 1);
    chk("overrun_y", obs_at(0), -1562);
    strobe(18'd7, 10);
    idle(2);
    chk("no_shift_y", obs_at(1), -2344);
    chk("overrun_sticky", int'(ovr3), 1);

    // Reset in the middle of MAC abandons the computation
    strobe(18'd1000, 4);
    reset = 1'b0;
    idle(1);
    reset = 1'b1;
    idle(15);
    chk("abandon_count", obs_y.size(), 2);
    chk("abandon_y", int'($signed(y0)), 0);
    chk("abandon_overrun", int'(ovr0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
